// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between the decode stage and the ALU issue controller.
// master drives requests and consumes responses; slave is the controller.
interface alu_issue_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_alu_op;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [DATA_WIDTH-1:0] in_src_a;
  logic [DATA_WIDTH-1:0] in_src_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic                  out_taken;
  logic                  out_err;

  modport master (
    output in_valid, in_alu_op, in_funct3, in_funct7, in_src_a, in_src_b, out_ready,
    input  in_ready, out_valid, out_result, out_taken, out_err
  );

  modport slave (
    input  in_valid, in_alu_op, in_funct3, in_funct7, in_src_a, in_src_b, out_ready,
    output in_ready, out_valid, out_result, out_taken, out_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues decoded ALU requests to a combinational ALU and returns the captured result.
// One request in flight; a response slot can hand over directly to the next request.
module alu_issue_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_issue_ctrl_if.slave          bus,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [DATA_WIDTH-1:0]    ALUResult
);

  localparam logic [OPCODE_LENGTH-1:0] OpAnd   = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OpOr    = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OpAdd   = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OpSub   = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OpXor   = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OpEq    = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OpNe    = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OpUnsup = OPCODE_LENGTH'(4'b1111);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                   r_state, w_state_d;
  logic [OPCODE_LENGTH-1:0] r_op, w_op;
  logic [DATA_WIDTH-1:0]    r_src_a, r_src_b, r_result;
  logic                     r_is_branch, r_err, r_taken, r_out_err;
  logic                     w_err, w_is_branch, w_in_ready, w_accept;

  always_comb begin
    w_op = OpUnsup;
    unique case (bus.in_alu_op)
      2'b00: w_op = OpAdd;
      2'b01: begin
        if (bus.in_funct3 == 3'b000)      w_op = OpEq;
        else if (bus.in_funct3 == 3'b001) w_op = OpNe;
      end
      2'b10, 2'b11: begin
        unique case (bus.in_funct3)
          // funct7[5] selects SUB only for register-register ops
          3'b000:  w_op = (bus.in_alu_op == 2'b10 && bus.in_funct7[5]) ? OpSub : OpAdd;
          3'b111:  w_op = OpAnd;
          3'b110:  w_op = OpOr;
          3'b100:  w_op = OpXor;
          default: w_op = OpUnsup;
        endcase
      end
      default: w_op = OpUnsup;
    endcase
    w_err       = (w_op == OpUnsup);
    w_is_branch = (bus.in_alu_op == 2'b01) && !w_err;
  end

  always_comb begin
    w_state_d  = r_state;
    w_in_ready = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_d = StExec;
      end
      StExec: w_state_d = StResp;
      StResp: begin
        w_in_ready = bus.out_ready;
        if (bus.out_ready) w_state_d = bus.in_valid ? StExec : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    w_accept = bus.in_valid && w_in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_op        <= OpUnsup;
      r_src_a     <= '0;
      r_src_b     <= '0;
      r_is_branch <= 1'b0;
      r_err       <= 1'b0;
      r_result    <= '0;
      r_taken     <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_op        <= w_op;
        r_src_a     <= bus.in_src_a;
        r_src_b     <= bus.in_src_b;
        r_is_branch <= w_is_branch;
        r_err       <= w_err;
      end
      if (r_state == StExec) begin
        r_result  <= r_err ? '0 : ALUResult;
        r_taken   <= r_is_branch && ALUResult[0];
        r_out_err <= r_err;
      end
    end
  end

  assign Operation      = r_op;
  assign SrcA           = r_src_a;
  assign SrcB           = r_src_b;
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == StResp);
  assign bus.out_result = r_result;
  assign bus.out_taken  = r_taken;
  assign bus.out_err    = r_out_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Operation;
  logic [31:0] SrcA, SrcB, ALUResult;
  int          n_vec = 0;
  int          n_bad = 0;

  alu_issue_ctrl_if #(.DATA_WIDTH(32)) bus ();

  alu_issue_ctrl #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ALUResult (ALUResult)
  );

  always #5 clk = ~clk;

  // Unimplemented codes return a marker so forced-zero results are visible.
  always_comb begin
    ALUResult = 32'hDEAD_BEEF;
    case (Operation)
      4'b0000: ALUResult = SrcA & SrcB;
      4'b0001: ALUResult = SrcA | SrcB;
      4'b0010: ALUResult = SrcA + SrcB;
      4'b0011: ALUResult = SrcA - SrcB;
      4'b0110: ALUResult = SrcA ^ SrcB;
      4'b1000: ALUResult = {31'b0, SrcA == SrcB};
      4'b1001: ALUResult = {31'b0, SrcA != SrcB};
      default: ALUResult = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_alu_op = op;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_src_a  = a;
    bus.in_src_b  = b;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] e_op, input logic [31:0] e_res,
                        input logic e_taken, input logic e_err);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive(op, f3, f7, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, ".exec_op"}, 32'(Operation), 32'(e_op));
    check({tag, ".exec_a"}, SrcA, a);
    check({tag, ".exec_b"}, SrcB, b);
    check({tag, ".exec_rdy"}, 32'(bus.in_ready), 32'd0);
    check({tag, ".exec_vld"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".op"}, 32'(Operation), 32'(e_op));
    check({tag, ".res"}, bus.out_result, e_res);
    check({tag, ".taken"}, 32'(bus.out_taken), 32'(e_taken));
    check({tag, ".err"}, 32'(bus.out_err), 32'(e_err));
  endtask

  logic [31:0] ta[4];
  logic [31:0] tb[4];

  initial begin
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(2'b00, 3'b000, 7'h00, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst.vld", 32'(bus.out_valid), 32'd0);
    check("rst.rdy", 32'(bus.in_ready), 32'd1);
    check("rst.op", 32'(Operation), 32'hF);
    check("rst.a", SrcA, 32'd0);
    check("rst.b", SrcB, 32'd0);
    check("rst.res", bus.out_result, 32'd0);
    check("rst.taken", 32'(bus.out_taken), 32'd0);
    check("rst.err", 32'(bus.out_err), 32'd0);
    reset = 1'b0;

    run_op("sub",    2'b10, 3'b000, 7'h20, 32'd5, 32'd7, 4'h3, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("add_r",  2'b10, 3'b000, 7'h00, 32'h100, 32'h23, 4'h2, 32'h123, 1'b0, 1'b0);
    run_op("and_r",  2'b10, 3'b111, 7'h00, 32'hF0F0, 32'h0FF0, 4'h0, 32'h00F0, 1'b0, 1'b0);
    run_op("or_r",   2'b10, 3'b110, 7'h00, 32'hF000, 32'h000F, 4'h1, 32'hF00F, 1'b0, 1'b0);
    run_op("xor_r",  2'b10, 3'b100, 7'h00, 32'hFF00, 32'h0FF0, 4'h6, 32'hF0F0, 1'b0, 1'b0);
    run_op("ldst",   2'b00, 3'b010, 7'h20, 32'h1000, 32'h4, 4'h2, 32'h1004, 1'b0, 1'b0);
    run_op("addi",   2'b11, 3'b000, 7'h20, 32'd7, 32'd9, 4'h2, 32'h10, 1'b0, 1'b0);
    run_op("andi",   2'b11, 3'b111, 7'h00, 32'hFF, 32'hF0, 4'h0, 32'hF0, 1'b0, 1'b0);
    run_op("beq",    2'b01, 3'b000, 7'h00, 32'h55, 32'h55, 4'h8, 32'h1, 1'b1, 1'b0);
    run_op("bne_eq", 2'b01, 3'b001, 7'h00, 32'h1234, 32'h1234, 4'h9, 32'h0, 1'b0, 1'b0);
    run_op("bne_ne", 2'b01, 3'b001, 7'h00, 32'd1, 32'd2, 4'h9, 32'h1, 1'b1, 1'b0);
    run_op("slti",   2'b11, 3'b010, 7'h00, 32'd1, 32'd2, 4'hF, 32'h0, 1'b0, 1'b1);
    run_op("blt",    2'b01, 3'b100, 7'h00, 32'd1, 32'd2, 4'hF, 32'h0, 1'b0, 1'b1);
    run_op("sll",    2'b10, 3'b001, 7'h00, 32'd1, 32'd2, 4'hF, 32'h0, 1'b0, 1'b1);

    // Backpressure: response held, new request ignored until out_ready.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(2'b10, 3'b000, 7'h00, 32'd10, 32'd20);
    @(negedge clk);
    drive(2'b10, 3'b111, 7'h00, 32'hF0, 32'h3C);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp.vld", 32'(bus.out_valid), 32'd1);
      check("bp.res", bus.out_result, 32'd30);
      check("bp.rdy", 32'(bus.in_ready), 32'd0);
      check("bp.op", 32'(Operation), 32'h2);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp.handoff_vld", 32'(bus.out_valid), 32'd0);
    check("bp.handoff_op", 32'(Operation), 32'h0);
    @(negedge clk);
    check("bp.next_vld", 32'(bus.out_valid), 32'd1);
    check("bp.next_res", bus.out_result, 32'h30);

    // Back-to-back: in_valid and out_ready held high across four ADDs.
    ta[0] = 32'd1;   tb[0] = 32'd2;
    ta[1] = 32'd100; tb[1] = 32'd200;
    ta[2] = 32'hFFFF_FFFF; tb[2] = 32'd1;
    ta[3] = 32'h8000_0000; tb[3] = 32'h7FFF_FFFF;
    @(negedge clk);
    check("b2b.idle", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    drive(2'b00, 3'b000, 7'h00, ta[0], tb[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b.exec_vld", 32'(bus.out_valid), 32'd0);
      if (i < 3) drive(2'b00, 3'b000, 7'h00, ta[i+1], tb[i+1]);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      check("b2b.vld", 32'(bus.out_valid), 32'd1);
      check("b2b.res", bus.out_result, ta[i] + tb[i]);
    end
    @(negedge clk);
    check("b2b.drain", 32'(bus.out_valid), 32'd0);
    check("b2b.rdy", 32'(bus.in_ready), 32'd1);

    // Reset while executing discards the request.
    bus.in_valid = 1'b1;
    drive(2'b10, 3'b100, 7'h00, 32'hAA, 32'h55);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rx.op", 32'(Operation), 32'h6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rx.vld", 32'(bus.out_valid), 32'd0);
    check("rx.op_rst", 32'(Operation), 32'hF);
    check("rx.rdy", 32'(bus.in_ready), 32'd1);
    check("rx.a", SrcA, 32'd0);
    @(negedge clk);
    check("rx.no_resp", 32'(bus.out_valid), 32'd0);
    check("rx.res", bus.out_result, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
